// File: rtl/keyinj_pkg.sv
// Shared types and key map for the keypad key injector.
// Optional registered row drive: define KEYINJ_ROW_REG_EN.
package keyinj_pkg;

  localparam int KEY_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    GAP
  } keyinj_state_t;

  // Row/column of each hex code on the 4x4 matrix
  localparam logic [1:0] KEY_ROW [16] = '{
    2'd3, 2'd0, 2'd0, 2'd0,
    2'd1, 2'd1, 2'd1, 2'd2,
    2'd2, 2'd2, 2'd0, 2'd1,
    2'd2, 2'd3, 2'd3, 2'd3
  };

  localparam logic [1:0] KEY_COL [16] = '{
    2'd0, 2'd0, 2'd1, 2'd2,
    2'd0, 2'd1, 2'd2, 2'd0,
    2'd1, 2'd2, 2'd3, 2'd3,
    2'd3, 2'd3, 2'd2, 2'd1
  };

  function automatic int cnt_width(
    input int a,
    input int b
  );
    int m;
    int w;
    m = (a > b) ? a : b;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/keyinj_fifo.sv
// Synchronous first-word-fall-through FIFO for queued key codes.
// Depth must be a power of two, at least 2.
module keyinj_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             wr;
  logic             rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr    = push && !full && !flush;
  assign rd    = pop && !empty;
  assign dout  = mem[rp];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      unique case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= din;
  end

endmodule

// File: rtl/keypad_key_injector.sv
// Keypad-side responder: replays queued key codes as timed switch closures.
// Define KEYINJ_ROW_REG_EN to register the row outputs.
module keypad_key_injector
  import keyinj_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int PRESS_CYCLES = 75_000_000,
  parameter int GAP_CYCLES   = 75_000_000
) (
  input  logic                        pulse_50Mhz,
  input  logic                        rst,
  input  logic [KEY_W-1:0]            key_in,
  input  logic                        key_valid,
  output logic                        key_ready,
  input  logic                        clear,
  input  logic [3:0]                  col,
  output logic [3:0]                  row,
  output logic                        pressing,
  output logic                        busy,
  output logic                        key_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CNT_W = cnt_width(PRESS_CYCLES, GAP_CYCLES);
  localparam logic [CNT_W-1:0] PRESS_LD = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);

  keyinj_state_t    state_q;
  keyinj_state_t    state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [KEY_W-1:0] key_q;
  logic [KEY_W-1:0] key_d;
  logic [KEY_W-1:0] head;
  logic             done_q;
  logic             done_d;
  logic             pop;
  logic             push;
  logic             full;
  logic             empty;
  logic [3:0]       row_c;

  assign key_ready = !full;
  assign push      = key_valid && !full && !clear;
  assign busy      = (state_q != IDLE) || !empty;
  assign key_done  = done_q;

  keyinj_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KEY_W)
  ) u_fifo (
    .clk   (pulse_50Mhz),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (clear),
    .din   (key_in),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_ff @(posedge pulse_50Mhz) begin
    if (rst || clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      key_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (!empty) begin
          pop     = 1'b1;
          key_d   = head;
          cnt_d   = PRESS_LD;
          state_d = PRESS;
        end
      end
      (state_q == PRESS): begin
        if (cnt_q == '0) begin
          cnt_d   = GAP_LD;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      (state_q == GAP): begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A closed switch ties the key's row line to its column strobe
  always_comb begin
    row_c    = 4'hF;
    pressing = 1'b0;
    if (state_q == PRESS) begin
      pressing            = 1'b1;
      row_c[KEY_ROW[key_q]] = col[KEY_COL[key_q]];
    end
  end

`ifdef KEYINJ_ROW_REG_EN
  logic [3:0] row_q;

  always_ff @(posedge pulse_50Mhz) begin
    if (rst || clear) begin
      row_q <= 4'hF;
    end else begin
      row_q <= row_c;
    end
  end

  assign row = row_q;
`else
  assign row = row_c;
`endif

endmodule

// File: tb/tb_keypad_key_injector.sv
// Directed scoreboard bench for keypad_key_injector.
// Short PRESS/GAP timing; row checks adapt to KEYINJ_ROW_REG_EN.
module tb_keypad_key_injector;

  localparam int DEPTH = 4;

  localparam logic [3:0] MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };

  logic       clk;
  logic       rst;
  logic [3:0] key_in;
  logic       key_valid;
  logic       key_ready;
  logic       clear;
  logic [3:0] col;
  logic [3:0] row;
  logic       pressing;
  logic       busy;
  logic       key_done;
  logic [2:0] fifo_count;

  int vectors;
  int miscompares;
  int done_cnt;
  int fifo_model;
  logic [3:0] exp_q [$];

  keypad_key_injector #(
    .FIFO_DEPTH   (DEPTH),
    .PRESS_CYCLES (8),
    .GAP_CYCLES   (4)
  ) dut (
    .pulse_50Mhz (clk),
    .rst         (rst),
    .key_in      (key_in),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .clear       (clear),
    .col         (col),
    .row         (row),
    .pressing    (pressing),
    .busy        (busy),
    .key_done    (key_done),
    .fifo_count  (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_done === 1'b1) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(
    input string      tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_pressing(input logic lvl, input string tag);
    int n = 0;
    while (pressing !== lvl && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {7'd0, pressing}, {7'd0, lvl});
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 128) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {7'd0, busy}, 8'd0);
  endtask

  task automatic probe(input logic [3:0] c, output logic [3:0] r);
    col = c;
    @(negedge clk);
    r = row;
  endtask

  task automatic sb_push(input logic [3:0] k);
    key_in    = k;
    key_valid = 1'b1;
    if (fifo_model < DEPTH) begin
      fifo_model++;
      exp_q.push_back(k);
    end
  endtask

  function automatic logic [4:0] decode(
    input logic [3:0] r_all,
    input logic [3:0] r_odd,
    input logic [3:0] r_lo
  );
    int r = 0;
    int hits = 0;
    logic [1:0] c;
    for (int i = 0; i < 4; i++) begin
      if (r_all[i] == 1'b0) begin
        r = i;
        hits++;
      end
    end
    if (hits != 1) return 5'h10;
    c = {r_lo[r], ~r_odd[r]};
    return {1'b0, MAP[r][c]};
  endfunction

  function automatic logic [4:0] sb_pop();
    if (exp_q.size() == 0) return 5'h1F;
    fifo_model = (fifo_model > 0) ? fifo_model - 1 : 0;
    return {1'b0, exp_q.pop_front()};
  endfunction

  task automatic check_next(input string tag);
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [4:0] got;
    wait_pressing(1'b1, tag);
    probe(4'b0000, a);
    probe(4'b0101, b);
    probe(4'b1100, c);
    col = 4'hF;
    got = decode(a, b, c);
    chk(tag, {3'd0, got}, {3'd0, sb_pop()});
    wait_pressing(1'b0, tag);
  endtask

  initial begin
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [4:0] got;
    int d0;

    vectors    = 0;
    miscompares = 0;
    fifo_model = 0;
    rst        = 1'b1;
    clear      = 1'b0;
    key_in     = 4'h0;
    key_valid  = 1'b0;
    col        = 4'h0;

    // 1: reset with col toggling
    repeat (2) begin
      @(negedge clk);
      col = ~col;
    end
    chk("rst_row", row, 4'hF);
    chk("rst_ready", key_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_press", pressing, 0);
    chk("rst_done", key_done, 0);
    rst = 1'b0;
    col = 4'hF;

    // 2: single key 5, timing and row drive
    key_in    = 4'h5;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    chk("k5_count", fifo_count, 1);
    chk("k5_press0", pressing, 0);
    chk("k5_busy0", busy, 1);
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      chk($sformatf("k5_press%0d", i), pressing, (i <= 8) ? 1 : 0);
      chk($sformatf("k5_done%0d", i), key_done, (i == 13) ? 1 : 0);
`ifdef KEYINJ_ROW_REG_EN
      if (i == 2) begin
        col = 4'b1101;
        #1;
        chk("k5_row_hold", row, 4'hF);
      end
      if (i == 3) begin
        chk("k5_row_c1", row, 4'b1101);
        col = 4'b1110;
        #1;
        chk("k5_row_hold2", row, 4'b1101);
      end
      if (i == 4) begin
        chk("k5_row_c0", row, 4'hF);
        col = 4'hF;
      end
`else
      if (i == 2) begin
        col = 4'b1101;
        #1;
        chk("k5_row_c1", row, 4'b1101);
      end
      if (i == 3) begin
        col = 4'b1110;
        #1;
        chk("k5_row_c0", row, 4'hF);
        col = 4'hF;
      end
`endif
    end
    chk("k5_busy_end", busy, 0);

    // 3: fill the FIFO while key 1 is held
    d0 = done_cnt;
    sb_push(4'h1);
    @(negedge clk);
    key_valid = 1'b0;
    @(negedge clk);
    fifo_model = 0;
    sb_push(4'h2);
    col = 4'b0000;
    @(negedge clk);
    a = row;
    sb_push(4'h3);
    col = 4'b0101;
    @(negedge clk);
    b = row;
    sb_push(4'h4);
    col = 4'b1100;
    @(negedge clk);
    c = row;
    sb_push(4'hA);
    col = 4'hF;
    @(negedge clk);
    sb_push(4'hB);
    @(negedge clk);
    key_valid = 1'b0;
    chk("fill_count", fifo_count, fifo_model);
    chk("fill_ready", key_ready, (fifo_model < DEPTH) ? 1 : 0);
    got = decode(a, b, c);
    chk("order_k1", {3'd0, got}, {3'd0, exp_q.pop_front()});
    wait_pressing(1'b0, "k1_release");
    check_next("order_k2");
    check_next("order_k3");
    check_next("order_k4");
    check_next("order_kA");
    wait_idle("fill_idle");
    repeat (2) @(negedge clk);
    chk("fill_dones", done_cnt - d0, 5);
    chk("fill_drained", fifo_count, 0);
    chk("fill_leftover", exp_q.size(), 0);

    // 4: key D and key F row mapping
    key_in    = 4'hD;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    wait_pressing(1'b1, "kD_start");
    probe(4'b0000, a);
    chk("kD_row", a, 4'b0111);
    col = 4'hF;
    wait_idle("kD_idle");
    key_in    = 4'hF;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    wait_pressing(1'b1, "kF_start");
    probe(4'b1101, a);
    chk("kF_row_c1", a, 4'b0111);
    probe(4'b1011, a);
    chk("kF_row_c2", a, 4'hF);
    col = 4'hF;
    wait_idle("kF_idle");
    @(negedge clk);

    // 5: abort mid-press, first via clear then via rst
    for (int pass = 0; pass < 2; pass++) begin
      key_in    = 4'h7;
      key_valid = 1'b1;
      @(negedge clk);
      key_valid = 1'b0;
      @(negedge clk);
      key_in    = 4'h8;
      key_valid = 1'b1;
      col       = 4'b0000;
      @(negedge clk);
      key_in = 4'h9;
      @(negedge clk);
      chk($sformatf("ab%0d_row_pre", pass), row, 4'b1011);
      chk($sformatf("ab%0d_cnt_pre", pass), fifo_count, 2);
      d0     = done_cnt;
      key_in = 4'h2;
      if (pass == 0) clear = 1'b1;
      else           rst   = 1'b1;
      @(negedge clk);
      clear     = 1'b0;
      rst       = 1'b0;
      key_valid = 1'b0;
      chk($sformatf("ab%0d_row", pass), row, 4'hF);
      chk($sformatf("ab%0d_press", pass), pressing, 0);
      chk($sformatf("ab%0d_count", pass), fifo_count, 0);
      chk($sformatf("ab%0d_busy", pass), busy, 0);
      chk($sformatf("ab%0d_ready", pass), key_ready, 1);
      chk($sformatf("ab%0d_done", pass), key_done, 0);
      repeat (16) @(negedge clk);
      chk($sformatf("ab%0d_nodone", pass), done_cnt - d0, 0);
      chk($sformatf("ab%0d_still", pass), pressing, 0);
      col = 4'hF;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keypad_key_injector.md
Name: keypad_key_injector

Overview:
- Electrical "keypad side" of the 4x4 matrix interface. It is the responder to the keypad scanner/decoder.
- Accepts 4-bit key codes on a valid/ready stream into a small FIFO. Replays each code as a timed press followed by a release.
- While pressing, it drives the active-low row lines from the active-low column strobes, exactly as a closed switch would.
- Used for board self-test and loopback of the digital-lock entry path, and as a synthesizable bench model.

Parameters:
- FIFO_DEPTH, 4: key codes buffered; power of two, at least 2.
- PRESS_CYCLES, 75_000_000: clock cycles a key is held. The default is 1.5 s, which exceeds the 1000 ms debounce window.
- GAP_CYCLES, 75_000_000: clock cycles of release after each press.

Ports:
- pulse_50Mhz  in  1  system clock
- rst  in  1  synchronous, active-high reset
- key_in  in  4  hex key code to inject
- key_valid  in  1  key_in valid
- key_ready  out  1  FIFO can accept; equals not full
- clear  in  1  synchronous flush: empty the FIFO and abort the current key
- col  in  4  column strobes from the scanner, active-low
- row  out  4  row lines to the scanner, active-low, idle 4'hF
- pressing  out  1  high while in state PRESS
- busy  out  1  state not IDLE, or FIFO not empty
- key_done  out  1  one-cycle pulse when a key's GAP completes
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- One clock, pulse_50Mhz. Reset is synchronous and active-high on rst.
- Reset values: row=4'hF, key_ready=1, pressing=0, busy=0, key_done=0, fifo_count=0, state=IDLE, counter=0.
- Push: a key is written when key_valid && key_ready at the clock edge. When full, the push is ignored and the code dropped; no error flag.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into cur_key, load the counter with PRESS_CYCLES-1, go to PRESS. A key pushed at edge N enters PRESS at edge N+1.
  - PRESS: decrement each cycle. At 0, load GAP_CYCLES-1 and go to GAP. pressing is high for exactly PRESS_CYCLES cycles.
  - GAP: decrement each cycle. At 0, go to IDLE and assert key_done for the next single cycle.
- Back-to-back keys: one IDLE cycle always separates GAP and the next PRESS.
- Key map, with index r/c meaning row[r]/col[c]:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
  - (listed for c0..c3)
- Row drive: in PRESS, row[r_key] = col[c_key]; all other row bits are 1. Outside PRESS, row=4'hF.
- Row drive is zero-latency combinational from col and registered state, modelling a passive switch.
- Col not one-hot: follows the same rule. col=4'b0000 pulls row[r_key] low; col=4'hF leaves row=4'hF.
- clear: next cycle state=IDLE, FIFO empty, row=4'hF, no key_done.
  - clear takes priority over a simultaneous push; the push is dropped.
- rst mid-operation: identical to clear, and all outputs return to their reset values.
- Simultaneous push and pop (IDLE pop with a valid push): both occur; fifo_count is unchanged.
- Counters are sized $clog2(max(PRESS_CYCLES,GAP_CYCLES)) bits and never wrap. They are unsigned and saturate at 0.

Optional Feature:
- Macro KEYINJ_ROW_REG_EN.
- Defined: row is registered, adding one cycle from col/state to row. Its reset value is 4'hF. This removes the combinational col-to-row path for timing closure.
- Undefined: combinational row as specified above.
- Timing for state/key_done/pressing is identical in both builds.

Decomposition:
- keyinj_pkg holds:
  - typedef enum logic [1:0] {IDLE, PRESS, GAP} keyinj_state_t
  - constant arrays KEY_ROW[16] and KEY_COL[16] (2-bit indices per hex code), implementing the map above
  - key code width localparam KEY_W=4
- One sub-module: keyinj_fifo.
  - Synchronous FWFT FIFO with push, pop, flush, full, empty, count.
  - Parameterised on depth and width.

Test Plan:
Bench parameters: PRESS_CYCLES=8, GAP_CYCLES=4, FIFO_DEPTH=4.
1. Reset: hold rst 2 cycles with col toggling -> row=4'hF, key_ready=1, busy=0, fifo_count=0.
2. Push 4'h5 at edge 0 -> pressing high edges 1..8 (8 cycles).
   - During PRESS: col=4'b1101 -> row=4'b1101; col=4'b1110 -> row=4'hF.
   - key_done is one cycle, 13 cycles after the push; then busy=0.
3. Fill: during PRESS of key 1, push 2,3,4,A,B in consecutive cycles -> fifo_count reaches 4, key_ready=0, B dropped.
   - Replay order 1,2,3,4,A. Exactly 5 key_done pulses.
4. Key D, col=4'b0000 -> row=4'b0111. Key F with col=4'b1101 -> row=4'b0111. Key F with col=4'b1011 -> row=4'hF.
5. clear at PRESS cycle 3 with 2 keys queued -> next cycle row=4'hF, pressing=0, fifo_count=0, no key_done. Same sequence using rst gives the same result.
6. KEYINJ_ROW_REG_EN build: repeat scenario 2 -> row responds one cycle after the col change. pressing and key_done timing unchanged.
